mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 140001, number of 32-bit words in the data RAM.
REQ-002 SHALL have ports:
  clk  in  1  sole clock, all state updates on rising edge
  rst  in  1  reset, synchronous, active-high
  req_valid  in  1  core request present
  req_ready  out  1  unit can accept a request this cycle
  req_we  in  1  1=store, 0=load
  req_size  in  2  00=byte, 10=word, 01/11 reserved
  req_unsigned  in  1  byte load zero-extends when 1, sign-extends when 0
  req_addr  in  32  byte address
  req_wdata  in  32  store data (byte store uses bits 7:0)
  resp_valid  out  1  load response / error present
  resp_ready  in  1  core accepts response
  resp_rdata  out  32  formatted load data
  resp_err  out  1  request was rejected, no RAM access made
  mem_ena, mem_wea  out  1 each  RAM write-port enable / write enable
  mem_addra, mem_dia  out  32 each  RAM write word address / data
  mem_enb  out  1  RAM read-port enable
  mem_addrb  out  32  RAM read word address
  mem_dob  in  32  RAM read data, valid the cycle after mem_enb
REQ-003 Single clock domain; reset synchronous and active-high, exactly as above.

Function
REQ-004 Request accepted iff req_valid && req_ready; req_ready=1 only in IDLE.
REQ-005 Word index = req_addr[31:2]; byte lane = req_addr[1:0], lane 0 = bits 7:0 (little-endian).
REQ-006 Error iff size reserved, word with addr[1:0]!=0, or word index >= MEM_DEPTH; error -> RESP with resp_err=1, resp_rdata=0, no mem_ena/mem_enb, for loads and stores.
REQ-007 States IDLE, READ, WAIT, MERGE_WR, WRITE, RESP; all memory outputs registered.
REQ-008 IDLE: word store -> WRITE; load or byte store -> READ; error -> RESP; no request -> IDLE.
REQ-009 WRITE: mem_ena=mem_wea=1 with mem_addra/mem_dia for exactly one cycle -> IDLE.
REQ-010 READ: mem_enb=1, mem_addrb=word index, one cycle -> WAIT.
REQ-011 WAIT: load -> capture formatted mem_dob into resp_rdata -> RESP; byte store -> MERGE_WR.
REQ-012 MERGE_WR: mem_dob with selected lane replaced by req_wdata[7:0]; ena/wea asserted one cycle -> IDLE.
REQ-013 RESP: resp_valid=1, resp_rdata/resp_err stable until resp_ready=1 -> IDLE next cycle.
REQ-014 Latency (accept at cycle N): word store write cycle N+1, ready N+2; load resp_valid N+3; byte store write N+3, ready N+4; error resp_valid N+1.
REQ-015 Word load returns mem_dob unchanged; byte load returns lane extended to 32 bits per req_unsigned.
REQ-016 Request fields latched at acceptance; later input changes ignored until IDLE.
REQ-017 mem_ena and mem_enb never asserted in the same cycle; enables low in every state not listed above.

Reset
REQ-018 rst=1 at any edge -> IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_ena=mem_wea=mem_enb=0, addresses/data 0.
REQ-019 Reset mid-operation drops the in-flight request: no write issued after the reset edge, no response produced.
REQ-020 RAM contents are not affected by reset.

Structure
REQ-021 Shared package mem_pkg holds size encodings, state enum, MEM_DEPTH default.
REQ-022 One combinational sub-module mem_lane_fmt: byte extract/extend and byte merge.

Verification
REQ-023 Word store 0xDEADBEEF to addr 0x40, then word load 0x40 -> mem_ena at N+1 with mem_addra=0x10; resp_rdata=0xDEADBEEF at N+3.
REQ-024 RAM[0x10]=0x11223344; byte store 0xAA to 0x42 -> MERGE_WR writes 0x11AA3344 at N+3; ready at N+4.
REQ-025 RAM[0x10]=0x11AA3344; byte load 0x42 signed -> 0xFFFFFFAA; unsigned -> 0x000000AA.
REQ-026 Word load 0x41, and word load index MEM_DEPTH -> resp_err=1 at N+1, no mem_enb; resp_ready low 3 cycles -> resp held stable.
REQ-027 rst asserted in WAIT of byte store -> no mem_ena ever, resp_valid 0, req_ready 1 next cycle, RAM word unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings, state enum and depth default for the memory access unit
package mem_pkg;

    localparam int MEM_DEPTH_DEFAULT = 140001;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_MERGE_WR,
        ST_WRITE,
        ST_RESP
    } state_t;

endpackage

// File: rtl/mem_lane_fmt.sv
// rtl/mem_lane_fmt.sv - byte lane extract/extend for loads and byte merge for stores
module mem_lane_fmt (
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic        is_byte,
    input  logic        zero_ext,
    input  logic [7:0]  wbyte,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0] sel;

    // Little-endian lanes: lane 0 is bits 7:0; byte loads extend, byte stores splice in
    always_comb begin
        sel    = word[{lane, 3'b000} +: 8];
        rdata  = is_byte ? {{24{~zero_ext & sel[7]}}, sel} : word;
        merged = word;
        merged[{lane, 3'b000} +: 8] = wbyte;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store unit bridging a core request port to a dual-port word RAM
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_ena,
    output logic        mem_wea,
    output logic [31:0] mem_addra,
    output logic [31:0] mem_dia,
    output logic        mem_enb,
    output logic [31:0] mem_addrb,
    input  logic [31:0] mem_dob
);

    state_t      state, state_n;
    logic        accept;
    logic        req_bad;
    logic [31:0] req_index;

    // Request fields held from acceptance until the unit returns to IDLE
    logic        we_q;
    logic        byte_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [31:0] index_q;
    logic [7:0]  wbyte_q;

    logic        resp_err_n;
    logic [31:0] resp_rdata_n, mem_addra_n, mem_dia_n, mem_addrb_n;
    logic [31:0] fmt_rdata, fmt_merged;

    assign accept    = req_valid && req_ready;
    assign req_index = {2'b00, req_addr[31:2]};
    assign req_bad   = !(req_size == SIZE_BYTE || req_size == SIZE_WORD)
                    || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
                    || (req_index >= 32'(MEM_DEPTH));

    mem_lane_fmt u_fmt (
        .word     (mem_dob),
        .lane     (lane_q),
        .is_byte  (byte_q),
        .zero_ext (uns_q),
        .wbyte    (wbyte_q),
        .rdata    (fmt_rdata),
        .merged   (fmt_merged)
    );

    // Next state plus next values of the registered response/memory outputs
    always_comb begin
        state_n      = state;
        resp_err_n   = resp_err;
        resp_rdata_n = resp_rdata;
        mem_addra_n  = mem_addra;
        mem_dia_n    = mem_dia;
        mem_addrb_n  = mem_addrb;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        state_n      = ST_RESP;
                        resp_err_n   = 1'b1;
                        resp_rdata_n = '0;
                    end else if (req_we && req_size == SIZE_WORD) begin
                        state_n     = ST_WRITE;
                        mem_addra_n = req_index;
                        mem_dia_n   = req_wdata;
                    end else begin
                        state_n     = ST_READ;
                        mem_addrb_n = req_index;
                    end
                end
            end
            ST_READ:     state_n = ST_WAIT;
            ST_WAIT: begin
                if (we_q) begin
                    state_n     = ST_MERGE_WR;
                    mem_addra_n = index_q;
                    mem_dia_n   = fmt_merged;
                end else begin
                    state_n      = ST_RESP;
                    resp_err_n   = 1'b0;
                    resp_rdata_n = fmt_rdata;
                end
            end
            ST_MERGE_WR: state_n = ST_IDLE;
            ST_WRITE:    state_n = ST_IDLE;
            ST_RESP:     if (resp_ready) state_n = ST_IDLE;
            default:     state_n = ST_IDLE;
        endcase
    end

    // State and all outputs registered; strobes decode the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_ena    <= 1'b0;
            mem_wea    <= 1'b0;
            mem_enb    <= 1'b0;
            mem_addra  <= '0;
            mem_dia    <= '0;
            mem_addrb  <= '0;
        end else begin
            state      <= state_n;
            req_ready  <= (state_n == ST_IDLE);
            resp_valid <= (state_n == ST_RESP);
            resp_err   <= resp_err_n;
            resp_rdata <= resp_rdata_n;
            mem_ena    <= (state_n == ST_WRITE) || (state_n == ST_MERGE_WR);
            mem_wea    <= (state_n == ST_WRITE) || (state_n == ST_MERGE_WR);
            mem_enb    <= (state_n == ST_READ);
            mem_addra  <= mem_addra_n;
            mem_dia    <= mem_dia_n;
            mem_addrb  <= mem_addrb_n;
        end
    end

    // Capture request fields on acceptance only
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            uns_q   <= 1'b0;
            lane_q  <= '0;
            index_q <= '0;
            wbyte_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            byte_q  <= (req_size == SIZE_BYTE);
            uns_q   <= req_unsigned;
            lane_q  <= req_addr[1:0];
            index_q <= req_index;
            wbyte_q <= req_wdata[7:0];
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed table-driven bench for mem_access_ctrl
module tb_mem_access_ctrl;

    localparam int DEPTH = 140001;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_ena, mem_wea, mem_enb;
    logic [31:0] mem_addra, mem_dia, mem_addrb, mem_dob;

    logic [31:0] ram [0:DEPTH-1];

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_ena      (mem_ena),
        .mem_wea      (mem_wea),
        .mem_addra    (mem_addra),
        .mem_dia      (mem_dia),
        .mem_enb      (mem_enb),
        .mem_addrb    (mem_addrb),
        .mem_dob      (mem_dob)
    );

    // Behavioural dual-port RAM with one-cycle read latency
    always @(posedge clk) begin
        if (mem_ena && mem_wea && mem_addra < DEPTH) ram[mem_addra] <= mem_dia;
        if (mem_enb) mem_dob <= (mem_addrb < DEPTH) ? ram[mem_addrb] : 32'h0;
    end

    // Both ports must never be enabled together
    always @(negedge clk) begin
        if (mem_ena && mem_enb) begin
            total_cnt++;
            $display("FAIL ena_enb_overlap: ena=%0b enb=%0b required not both", mem_ena, mem_enb);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] exp;   // load data, or RAM word written for stores
        int          hold;  // cycles resp_ready is held low
    } vec_t;

    vec_t vecs[18];

    task automatic run_vec(input vec_t v, input int k);
        logic [31:0] idx;
        idx = v.addr >> 2;
        @(negedge clk);
        chk($sformatf("v%0d_ready_before", k), {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        @(negedge clk);  // cycle N+1
        // Scramble inputs to show fields were latched at acceptance
        req_valid = 1'b0; req_we = ~v.we; req_size = 2'b11; req_unsigned = ~v.uns;
        req_addr = 32'hFFFF_FFFD; req_wdata = 32'h5A5A_5A5A;
        if (v.err) begin
            chk($sformatf("v%0d_err_valid", k), {29'b0, resp_valid, resp_err, mem_enb}, 32'b110);
            chk($sformatf("v%0d_err_rdata", k), resp_rdata, 32'h0);
            chk($sformatf("v%0d_err_noena", k), {31'b0, mem_ena}, 32'd0);
            for (int h = 0; h < v.hold; h++) begin
                resp_ready = 1'b0;
                @(negedge clk);
                chk($sformatf("v%0d_hold%0d", k, h), {30'b0, resp_valid, resp_err}, 32'b11);
                chk($sformatf("v%0d_hold%0d_rdata", k, h), resp_rdata, 32'h0);
            end
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            chk($sformatf("v%0d_err_done", k), {30'b0, req_ready, resp_valid}, 32'b10);
        end else if (v.we && v.size == 2'b10) begin
            chk($sformatf("v%0d_wr_en", k), {30'b0, mem_ena, mem_wea}, 32'b11);
            chk($sformatf("v%0d_wr_addr", k), mem_addra, idx);
            chk($sformatf("v%0d_wr_data", k), mem_dia, v.exp);
            @(negedge clk);  // N+2
            chk($sformatf("v%0d_wr_done", k), {30'b0, req_ready, mem_ena}, 32'b10);
        end else begin
            chk($sformatf("v%0d_rd_en", k), {30'b0, mem_enb, mem_ena}, 32'b10);
            chk($sformatf("v%0d_rd_addr", k), mem_addrb, idx);
            @(negedge clk);  // N+2
            chk($sformatf("v%0d_wait_quiet", k), {29'b0, mem_ena, mem_enb, resp_valid}, 32'b0);
            @(negedge clk);  // N+3
            if (v.we) begin
                chk($sformatf("v%0d_merge_en", k), {30'b0, mem_ena, mem_wea}, 32'b11);
                chk($sformatf("v%0d_merge_addr", k), mem_addra, idx);
                chk($sformatf("v%0d_merge_data", k), mem_dia, v.exp);
                @(negedge clk);  // N+4
                chk($sformatf("v%0d_merge_done", k), {30'b0, req_ready, mem_ena}, 32'b10);
            end else begin
                chk($sformatf("v%0d_resp", k), {30'b0, resp_valid, resp_err}, 32'b10);
                chk($sformatf("v%0d_rdata", k), resp_rdata, v.exp);
                resp_ready = 1'b1;
                @(negedge clk);
                resp_ready = 1'b0;
                chk($sformatf("v%0d_ld_done", k), {30'b0, req_ready, resp_valid}, 32'b10);
            end
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 0};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        1'b0, 32'hDEADBEEF, 0};
        vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, 1'b0, 32'h11223344, 0};
        vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h42, 32'h000000AA, 1'b0, 32'h11AA3344, 0};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h42, 32'h0,        1'b0, 32'hFFFFFFAA, 0};
        vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h42, 32'h0,        1'b0, 32'h000000AA, 0};
        vecs[6]  = '{1'b0, 2'b00, 1'b0, 32'h40, 32'h0,        1'b0, 32'h00000044, 0};
        vecs[7]  = '{1'b0, 2'b00, 1'b0, 32'h43, 32'h0,        1'b0, 32'h00000011, 0};
        vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h43, 32'h12345680, 1'b0, 32'h80AA3344, 0};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        1'b0, 32'h80AA3344, 0};
        vecs[10] = '{1'b0, 2'b00, 1'b1, 32'h43, 32'h0,        1'b0, 32'h00000080, 0};
        vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h43, 32'h0,        1'b0, 32'hFFFFFF80, 0};
        vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h41, 32'h0,        1'b1, 32'h0,        3};
        vecs[13] = '{1'b0, 2'b10, 1'b0, 32'(DEPTH*4), 32'h0,  1'b1, 32'h0,        3};
        vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h42, 32'h99999999, 1'b1, 32'h0,        0};
        vecs[15] = '{1'b0, 2'b01, 1'b0, 32'h40, 32'h0,        1'b1, 32'h0,        0};
        vecs[16] = '{1'b1, 2'b10, 1'b0, 32'((DEPTH-1)*4), 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 0};
        vecs[17] = '{1'b0, 2'b10, 1'b0, 32'((DEPTH-1)*4), 32'h0, 1'b0, 32'hCAFEF00D, 0};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_flags", {26'b0, req_ready, resp_valid, resp_err, mem_ena, mem_wea, mem_enb}, 32'b100000);
        chk("reset_rdata", resp_rdata, 32'h0);
        chk("reset_addrs", mem_addra | mem_dia | mem_addrb, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

        // Reset while a byte store sits in WAIT: no write, no response, RAM untouched
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h41; req_wdata = 32'h55;
        @(negedge clk);  // N+1 READ
        req_valid = 1'b0;
        @(negedge clk);  // N+2 WAIT
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_idle", {29'b0, req_ready, resp_valid, mem_ena}, 32'b100);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst_mid_quiet%0d", c), {30'b0, mem_ena, resp_valid}, 32'b0);
        end
        run_vec('{1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, 32'h80AA3344, 0}, 99);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
